// File: rtl/xadc_pkg.sv
//------------------------------------------------------------------
// xadc_pkg - shared DRP widths, FSM state type and register addresses
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package xadc_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  localparam logic [DRP_ADDR_W-1:0] ADC_OUTPUT_ADDR = 7'h10;
  localparam logic [DRP_ADDR_W-1:0] TEMP_ADDR       = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } drp_state_e;

endpackage

`default_nettype wire

// File: rtl/drp_rr_arb2.sv
//------------------------------------------------------------------
// drp_rr_arb2 - two-way round-robin grant, one-hot output
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module drp_rr_arb2
  import xadc_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Under contention the requester not served last time wins.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/xadc_drp_arbiter.sv
//------------------------------------------------------------------
// xadc_drp_arbiter - shares the XADC DRP port between two requesters
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_we,
  input  logic [13:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic [1:0]            req_accept,
  output logic [1:0]            rsp_valid,
  output logic [DRP_DATA_W-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic                  DCLK,
  output logic [DRP_ADDR_W-1:0] DADDR,
  output logic [DRP_DATA_W-1:0] DI,
  output logic                  DWE,
  output logic                  DEN,
  input  logic [DRP_DATA_W-1:0] DO,
  input  logic                  DRDY
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  drp_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  dwe_q, dwe_d;
  logic [DRP_ADDR_W-1:0] daddr_q, daddr_d;
  logic [DRP_DATA_W-1:0] di_q, di_d;
  logic [DRP_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [1:0]            grant;
  logic [1:0]            accept;
  logic                  sel_we;
  logic [DRP_ADDR_W-1:0] sel_addr;
  logic [DRP_DATA_W-1:0] sel_wdata;

  drp_rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign sel_we    = grant[1] ? req_we[1]          : req_we[0];
  assign sel_addr  = grant[1] ? req_addr[13:7]     : req_addr[6:0];
  assign sel_wdata = grant[1] ? req_wdata[31:16]   : req_wdata[15:0];

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    dwe_d         = dwe_q;
    daddr_d       = daddr_q;
    di_d          = di_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    accept        = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          accept       = grant;
          last_grant_d = grant[1];
          dwe_d        = sel_we;
          daddr_d      = sel_addr;
          di_d         = sel_wdata;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // DRDY is checked first so it wins on the final timeout cycle.
        if (DRDY) begin
          rsp_data_d    = dwe_q ? '0 : DO;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      dwe_q         <= 1'b0;
      daddr_q       <= '0;
      di_q          <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      dwe_q         <= dwe_d;
      daddr_q       <= daddr_d;
      di_q          <= di_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  // Accept is combinational from IDLE, so it is masked while reset is held.
  assign req_accept  = rst ? accept : 2'b00;
  assign rsp_valid   = (state_q == ST_RESP) ? (last_grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_timeout = (state_q == ST_RESP) && rsp_timeout_q;
  assign rsp_data    = rsp_data_q;

  assign DCLK  = clk;
  assign DEN   = (state_q == ST_ISSUE);
  assign DWE   = dwe_q;
  assign DADDR = daddr_q;
  assign DI    = di_q;

endmodule

`default_nettype wire

// File: tb/tb_xadc_drp_arbiter.sv
//------------------------------------------------------------------
// tb_xadc_drp_arbiter - self-checking bench with a DRP slave model
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_xadc_drp_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_accept, rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic        DCLK;
  logic [6:0]  DADDR;
  logic [15:0] DI;
  logic        DWE, DEN;
  logic [15:0] DO;
  logic        DRDY;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_g;
  int drp_delay;

  logic [15:0] ref_mem [0:127];
  logic [15:0] drp_mem [0:127];
  bit          pend;
  int          pend_cyc;
  logic        pend_we;
  logic [15:0] pend_data;

  xadc_drp_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_accept(req_accept),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .DCLK(DCLK), .DADDR(DADDR), .DI(DI), .DWE(DWE), .DEN(DEN),
    .DO(DO), .DRDY(DRDY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DRP slave: answers drp_delay cycles after the DEN cycle, never if the delay is huge
  always @(negedge clk) begin
    if (!rst) begin
      DRDY = 1'b0;
      pend = 1'b0;
    end else begin
      DRDY = 1'b0;
      if (pend && cyc == pend_cyc) begin
        DRDY = 1'b1;
        DO   = pend_we ? 16'($urandom) : pend_data;
        pend = 1'b0;
      end
      if (DEN) begin
        if (DWE) drp_mem[DADDR] = DI;
        pend_we   = DWE;
        pend_data = drp_mem[DADDR];
        pend      = 1'b1;
        pend_cyc  = cyc + drp_delay;
      end
    end
  end

  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return (last == 1) ? 0 : 1;
    return (v == 2'b10) ? 1 : 0;
  endfunction

  task automatic run_txn(input logic [1:0] vmask, input bit hold, input logic [1:0] we,
                         input logic [6:0] a0, input logic [6:0] a1,
                         input logic [15:0] w0, input logic [15:0] w1, input int d,
                         output bit ok, output logic [1:0] acc, output int lat, output int dens,
                         output logic [6:0] daddr, output logic dwe, output logic [15:0] di,
                         output logic [1:0] rv, output logic [15:0] rd, output logic rto);
    bit got;
    drp_delay = d;
    req_valid = vmask; req_we = we; req_addr = {a1, a0}; req_wdata = {w1, w0};
    ok = 0; acc = 0; lat = 0; dens = 0; daddr = 0; dwe = 0; di = 0; rv = 0; rd = 0; rto = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (req_accept != 2'b00) begin got = 1; acc = req_accept; end
      else @(negedge clk);
    end
    if (!got) return;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!hold) req_valid = 2'b00;
      #1;
      lat++;
      if (DEN) begin dens++; daddr = DADDR; dwe = DWE; di = DI; end
      if (rsp_valid != 2'b00) begin ok = 1; rv = rsp_valid; rd = rsp_data; rto = rsp_timeout; end
    end
  endtask

  bit          ok;
  logic [1:0]  acc, rv;
  int          lat, dens;
  logic [6:0]  daddr;
  logic        dwe, rto;
  logic [15:0] di, rd;

  task automatic test_reset;
    rst = 1'b0; req_valid = 2'b11; req_we = 2'b11; req_addr = 14'h3fff; req_wdata = '1;
    drp_delay = 1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({req_accept, rsp_valid, DEN, DWE, DADDR, DI, rsp_data, rsp_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got acc=%b rv=%b den=%b dwe=%b addr=%h di=%h d=%h to=%b want all 0",
               req_accept, rsp_valid, DEN, DWE, DADDR, DI, rsp_data, rsp_timeout);
    end
    n_vec++;
    if (DCLK !== clk) begin n_err++; $display("FAIL dclk got %b want %b", DCLK, clk); end
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    last_g = 1;
    @(negedge clk);
  endtask

  task automatic test_single_read;
    run_txn(2'b01, 0, 2'b00, 7'h10, 7'h00, 16'h0, 16'h0, 2, ok, acc, lat, dens, daddr, dwe, di, rv, rd, rto);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rd_done got %b want 1", ok); end
    n_vec++; if (acc !== 2'b01) begin n_err++; $display("FAIL rd_accept got %b want 01", acc); end
    n_vec++; if (rv !== 2'b01) begin n_err++; $display("FAIL rd_rsp_valid got %b want 01", rv); end
    n_vec++; if (rd !== 16'hA5C3) begin n_err++; $display("FAIL rd_data got %h want a5c3", rd); end
    n_vec++; if (rto !== 1'b0) begin n_err++; $display("FAIL rd_timeout got %b want 0", rto); end
    n_vec++; if (dens != 1) begin n_err++; $display("FAIL rd_den_count got %0d want 1", dens); end
    n_vec++; if (daddr !== 7'h10 || dwe !== 1'b0) begin n_err++; $display("FAIL rd_drp_cmd got addr=%h we=%b want 10/0", daddr, dwe); end
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL rd_latency got %0d want 4", lat); end
    last_g = 0;
  endtask

  task automatic test_write;
    run_txn(2'b10, 0, 2'b10, 7'h00, 7'h41, 16'h0, 16'h1234, 3, ok, acc, lat, dens, daddr, dwe, di, rv, rd, rto);
    n_vec++; if (acc !== 2'b10) begin n_err++; $display("FAIL wr_accept got %b want 10", acc); end
    n_vec++; if (dens != 1) begin n_err++; $display("FAIL wr_den_count got %0d want 1", dens); end
    n_vec++; if (dwe !== 1'b1 || daddr !== 7'h41 || di !== 16'h1234) begin
      n_err++; $display("FAIL wr_drp_cmd got we=%b addr=%h di=%h want 1/41/1234", dwe, daddr, di);
    end
    n_vec++; if (rv !== 2'b10) begin n_err++; $display("FAIL wr_rsp_valid got %b want 10", rv); end
    n_vec++; if (rd !== 16'h0000 || rto !== 1'b0) begin n_err++; $display("FAIL wr_rsp got d=%h to=%b want 0000/0", rd, rto); end
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL wr_latency got %0d want 5", lat); end
    ref_mem[7'h41] = 16'h1234;
    last_g = 1;
  endtask

  task automatic test_contention;
    logic [6:0] a0, a1;
    int g;
    a0 = 7'h10; a1 = 7'h41;
    for (int k = 0; k < 4; k++) begin
      g = pick(2'b11, last_g);
      run_txn(2'b11, 1, 2'b00, a0, a1, 16'h0, 16'h0, 1, ok, acc, lat, dens, daddr, dwe, di, rv, rd, rto);
      n_vec++; if (acc !== (g ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL cont_grant[%0d] got %b want %0d", k, acc, g); end
      n_vec++; if (dens != 1 || ok !== 1'b1) begin n_err++; $display("FAIL cont_den[%0d] got %0d done=%b want 1", k, dens, ok); end
      n_vec++; if (rv !== acc || rd !== ref_mem[g ? a1 : a0]) begin
        n_err++; $display("FAIL cont_rsp[%0d] got rv=%b d=%h want rv=%b d=%h", k, rv, rd, acc, ref_mem[g ? a1 : a0]);
      end
      last_g = g;
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    run_txn(2'b01, 0, 2'b00, 7'h22, 7'h00, 16'h0, 16'h0, 100000, ok, acc, lat, dens, daddr, dwe, di, rv, rd, rto);
    n_vec++; if (rv !== 2'b01 || rto !== 1'b1 || rd !== 16'h0) begin
      n_err++; $display("FAIL to_rsp got rv=%b to=%b d=%h want 01/1/0000", rv, rto, rd);
    end
    n_vec++; if (lat != T + 2) begin n_err++; $display("FAIL to_latency got %0d want %0d", lat, T + 2); end
    last_g = 0;
    run_txn(2'b01, 0, 2'b00, 7'h23, 7'h00, 16'h0, 16'h0, T, ok, acc, lat, dens, daddr, dwe, di, rv, rd, rto);
    n_vec++; if (rto !== 1'b0 || rd !== ref_mem[7'h23]) begin
      n_err++; $display("FAIL to_edge got to=%b d=%h want 0/%h", rto, rd, ref_mem[7'h23]);
    end
    n_vec++; if (lat != T + 2) begin n_err++; $display("FAIL to_edge_latency got %0d want %0d", lat, T + 2); end
    run_txn(2'b01, 0, 2'b00, 7'h24, 7'h00, 16'h0, 16'h0, T + 1, ok, acc, lat, dens, daddr, dwe, di, rv, rd, rto);
    n_vec++; if (rto !== 1'b1 || rd !== 16'h0) begin n_err++; $display("FAIL to_late got to=%b d=%h want 1/0000", rto, rd); end
  endtask

  task automatic test_reset_mid;
    bit got;
    int spur;
    drp_delay = 100000;
    req_valid = 2'b01; req_we = 2'b00; req_addr = {7'h0, 7'h10}; req_wdata = '0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (req_accept != 2'b00) got = 1;
      else @(negedge clk);
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL rstmid_accept got none want 01"); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({req_accept, rsp_valid, DEN, DWE, DADDR, DI, rsp_data, rsp_timeout} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs got acc=%b rv=%b den=%b addr=%h d=%h want all 0", req_accept, rsp_valid, DEN, DADDR, rsp_data);
    end
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b1;
    spur = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (rsp_valid != 2'b00 || DEN) spur++;
    end
    n_vec++; if (spur != 0) begin n_err++; $display("FAIL rstmid_quiet got %0d busy cycles want 0", spur); end
    last_g = 1;
    run_txn(2'b11, 0, 2'b00, 7'h10, 7'h41, 16'h0, 16'h0, 2, ok, acc, lat, dens, daddr, dwe, di, rv, rd, rto);
    n_vec++; if (acc !== 2'b01 || rv !== 2'b01 || rd !== ref_mem[7'h10] || rto !== 1'b0) begin
      n_err++; $display("FAIL rstmid_after got acc=%b rv=%b d=%h to=%b want 01/01/%h/0", acc, rv, rd, rto, ref_mem[7'h10]);
    end
    last_g = 0;
  endtask

  task automatic test_random;
    logic [1:0]  m, we;
    logic [6:0]  a0, a1, ea;
    logic [15:0] w0, w1, ew, ed;
    int d, g, elat;
    bit eto;
    for (int t = 0; t < 24; t++) begin
      m  = 2'($urandom_range(1, 3));
      we = 2'($urandom);
      a0 = 7'($urandom); a1 = 7'($urandom);
      w0 = 16'($urandom); w1 = 16'($urandom);
      d  = $urandom_range(1, T + 2);
      g  = pick(m, last_g);
      run_txn(m, 0, we, a0, a1, w0, w1, d, ok, acc, lat, dens, daddr, dwe, di, rv, rd, rto);
      ea   = g ? a1 : a0;
      ew   = g ? w1 : w0;
      eto  = (d > T);
      ed   = (we[g] || eto) ? 16'h0 : ref_mem[ea];
      elat = (eto ? T : d) + 2;
      n_vec++; if (acc !== (g ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rnd_grant[%0d] got %b want %0d", t, acc, g); end
      n_vec++; if (dens != 1 || daddr !== ea || dwe !== we[g] || di !== ew) begin
        n_err++; $display("FAIL rnd_cmd[%0d] got n=%0d a=%h we=%b di=%h want 1/%h/%b/%h", t, dens, daddr, dwe, di, ea, we[g], ew);
      end
      n_vec++; if (rv !== (g ? 2'b10 : 2'b01) || rd !== ed || rto !== eto) begin
        n_err++; $display("FAIL rnd_rsp[%0d] got rv=%b d=%h to=%b want %0d/%h/%b", t, rv, rd, rto, g, ed, eto);
      end
      n_vec++; if (lat != elat) begin n_err++; $display("FAIL rnd_latency[%0d] got %0d want %0d", t, lat, elat); end
      if (we[g]) ref_mem[ea] = ew;
      last_g = g;
    end
  endtask

  initial begin
    DRDY = 1'b0; DO = '0; pend = 1'b0; drp_delay = 1;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
      drp_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    ref_mem[7'h10] = 16'hA5C3;
    drp_mem[7'h10] = 16'hA5C3;
    test_reset;
    test_single_read;
    test_write;
    test_contention;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
